// File: rtl/boson_capture.sv
// boson_capture: Boson CMOS parallel video capture front end.
// Oversamples the camera port and emits a framed pixel stream.
module boson_capture #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CMOS_CLK,
  input  logic        CMOS_VSYNC,
  input  logic        CMOS_HSYNC,
  input  logic        CMOS_VALID,
  input  logic [15:0] CMOS_DQ,
  input  logic        capture_en,
  input  logic        err_clr,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_sof,
  output logic        out_sol,
  output logic        line_done,
  output logic [15:0] last_line_len,
  output logic [15:0] line_count,
  output logic        frame_done,
  output logic [15:0] frames_captured,
  output logic        err_width,
  output logic        err_height,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ACTIVE
  } state_t;

  localparam logic [15:0] W = 16'(IMG_WIDTH);
  localparam logic [15:0] H = 16'(IMG_HEIGHT);

  state_t      state;
  logic        s1_clk, s1_vs, s1_hs, s1_va;
  logic [15:0] s1_dq;
  logic        s2_clk, s2_vs, s2_va;
  logic        s2_hs_unused;
  logic [15:0] s2_dq;
  logic        s3_clk;
  logic        prev_valid, prev_vsync, first_px;
  logic [15:0] pix_cnt;

  logic        pclk_rise, vs_rise, vs_fall, line_end;
  logic [15:0] pix_inc, lc_inc, lc_after;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_clk       <= 1'b0;
      s1_vs        <= 1'b0;
      s1_hs        <= 1'b0;
      s1_va        <= 1'b0;
      s1_dq        <= '0;
      s2_clk       <= 1'b0;
      s2_vs        <= 1'b0;
      s2_hs_unused <= 1'b0;
      s2_va        <= 1'b0;
      s2_dq        <= '0;
      s3_clk       <= 1'b0;
    end else begin
      s1_clk       <= CMOS_CLK;
      s1_vs        <= CMOS_VSYNC;
      s1_hs        <= CMOS_HSYNC;
      s1_va        <= CMOS_VALID;
      s1_dq        <= CMOS_DQ;
      s2_clk       <= s1_clk;
      s2_vs        <= s1_vs;
      s2_hs_unused <= s1_hs;
      s2_va        <= s1_va;
      s2_dq        <= s1_dq;
      s3_clk       <= s2_clk;
    end
  end

  assign pclk_rise = s2_clk & ~s3_clk;
  assign vs_rise   = s2_vs & ~prev_vsync;
  assign vs_fall   = prev_vsync & ~s2_vs;
  // A frame end also closes a line that is still open
  assign line_end  = prev_valid & (~s2_va | vs_fall);

  assign pix_inc  = (pix_cnt == 16'hFFFF) ? pix_cnt : pix_cnt + 16'd1;
  assign lc_inc   = (line_count == 16'hFFFF) ? line_count
                                             : line_count + 16'd1;
  assign lc_after = line_end ? lc_inc : line_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      prev_valid      <= 1'b0;
      prev_vsync      <= 1'b0;
      first_px        <= 1'b0;
      pix_cnt         <= '0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_sof         <= 1'b0;
      out_sol         <= 1'b0;
      line_done       <= 1'b0;
      last_line_len   <= '0;
      line_count      <= '0;
      frame_done      <= 1'b0;
      frames_captured <= '0;
      err_width       <= 1'b0;
      err_height      <= 1'b0;
      busy            <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_sol    <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      // Later set assignments override the clear
      if (err_clr) begin
        err_width  <= 1'b0;
        err_height <= 1'b0;
      end
      if (pclk_rise) begin
        prev_valid <= s2_va;
        prev_vsync <= s2_vs;
        unique case (state)
          IDLE: begin
            if (capture_en && !s2_vs) state <= ARMED;
          end
          ARMED: begin
            if (vs_rise) begin
              state      <= ACTIVE;
              busy       <= 1'b1;
              line_count <= '0;
              pix_cnt    <= '0;
              first_px   <= 1'b1;
            end else if (!capture_en) begin
              state <= IDLE;
            end
          end
          ACTIVE: begin
            if (s2_va) begin
              out_valid <= 1'b1;
              out_data  <= s2_dq;
              out_sol   <= ~prev_valid;
              out_sof   <= first_px;
              first_px  <= 1'b0;
              pix_cnt   <= pix_inc;
            end
            if (line_end) begin
              line_done     <= 1'b1;
              last_line_len <= pix_cnt;
              pix_cnt       <= '0;
              line_count    <= lc_inc;
              if (pix_cnt != W) err_width <= 1'b1;
            end
            if (vs_fall) begin
              frame_done      <= 1'b1;
              frames_captured <= frames_captured + 16'd1;
              if (lc_after != H) err_height <= 1'b1;
              state <= capture_en ? ARMED : IDLE;
              busy  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boson_capture.sv
// tb_boson_capture: randomized frames checked against a
// frame-level model of the expected pixel/line/frame stream.
module tb_boson_capture;
  localparam int W = 8;
  localparam int H = 4;

  logic        clk = 0;
  logic        reset = 1;
  logic        cmos_clk = 0, vs = 0, hs = 0, va = 0;
  logic [15:0] dq = 0;
  logic        cen = 0, err_clr = 0;
  logic        out_valid, out_sof, out_sol, line_done, frame_done;
  logic        err_width, err_height, busy;
  logic [15:0] out_data, last_line_len, line_count, frames_captured;

  always #5 clk = ~clk;

  boson_capture #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset),
    .CMOS_CLK(cmos_clk), .CMOS_VSYNC(vs), .CMOS_HSYNC(hs),
    .CMOS_VALID(va), .CMOS_DQ(dq),
    .capture_en(cen), .err_clr(err_clr),
    .out_valid(out_valid), .out_data(out_data),
    .out_sof(out_sof), .out_sol(out_sol),
    .line_done(line_done), .last_line_len(last_line_len),
    .line_count(line_count), .frame_done(frame_done),
    .frames_captured(frames_captured),
    .err_width(err_width), .err_height(err_height), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  // Events: {kind, sof, sol, value}; 0 pixel, 1 line, 2 frame
  logic [19:0] obs_q[$];
  logic [19:0] exp_q[$];
  int          m_frames = 0;
  bit          m_errw = 0, m_errh = 0;
  int          len_tab[16];

  always @(negedge clk) begin
    if (out_valid) obs_q.push_back({2'd0, out_sof, out_sol, out_data});
    if (line_done) obs_q.push_back({2'd1, 2'b00, last_line_len});
    if (frame_done) obs_q.push_back({2'd2, 2'b00, line_count});
  end

  // Keep camera edges away from clk edges
  task automatic realign();
    @(negedge clk);
    #2;
  endtask

  task automatic cam(input logic v_s, input logic v_a,
                     input logic [15:0] d);
    cmos_clk = 0; vs = v_s; va = v_a; hs = v_a; dq = d;
    #25;
    cmos_clk = 1;
    #25;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, {out_valid, out_sof, out_sol, line_done,
        frame_done, err_width, err_height, busy}, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_len"}, last_line_len, 0);
    chk({tag, "_lc"}, line_count, 0);
    chk({tag, "_fc"}, frames_captured, 0);
  endtask

  task automatic clear_errs();
    realign();
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    #1;
    m_errw = 0;
    m_errh = 0;
    chk("clr_errw", err_width, 0);
    chk("clr_errh", err_height, 0);
    realign();
  endtask

  task automatic send_frame(input int nl, input bit merge, input bit cap,
                            input int mid_line, input bit mid_cen,
                            input int rst_line);
    logic [15:0] d;
    bit first;
    first = 1;
    repeat (3) cam(0, 0, 0);
    repeat (2) cam(1, 0, 0);
    for (int i = 0; i < nl; i++) begin
      if (i == mid_line) cen = mid_cen;
      if (i == rst_line) begin
        @(negedge clk);
        #3 reset = 1;
        #1 check_zero("midrst");
        #20 reset = 0;
        cap = 0;
        m_frames = 0;
        m_errw = 0;
        m_errh = 0;
        realign();
      end
      if (cap && i == 0) chk("busy", busy, 1);
      for (int p = 0; p < len_tab[i]; p++) begin
        d = 16'($urandom);
        cam(1, 1, d);
        if (cap) exp_q.push_back({2'd0, first, p == 0, d});
        first = 0;
      end
      if (cap) begin
        exp_q.push_back({2'd1, 2'b00, 16'(len_tab[i])});
        if (len_tab[i] != W) m_errw = 1;
      end
      if (!(merge && i == nl - 1)) repeat (2) cam(1, 0, 0);
    end
    cam(0, 0, 0);
    if (cap) begin
      exp_q.push_back({2'd2, 2'b00, 16'(nl)});
      m_frames++;
      if (nl != H) m_errh = 1;
    end
  endtask

  task automatic compare(input string tag);
    int n;
    repeat (20) @(negedge clk);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
    chk({tag, "_frames"}, frames_captured, 16'(m_frames));
    chk({tag, "_errw"}, err_width, m_errw);
    chk({tag, "_errh"}, err_height, m_errh);
    realign();
  endtask

  task automatic reset_lens();
    for (int i = 0; i < 16; i++) len_tab[i] = W;
  endtask

  initial begin
    int nl;
    reset_lens();
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 0;
    cen = 1;
    realign();

    send_frame(H, 0, 1, -1, 0, -1);
    send_frame(H, 0, 1, -1, 0, -1);
    compare("good");

    len_tab[1] = W - 1;
    send_frame(H, 0, 1, -1, 0, -1);
    reset_lens();
    compare("short");
    send_frame(H, 0, 1, -1, 0, -1);
    compare("sticky");
    clear_errs();

    send_frame(H - 1, 0, 1, -1, 0, -1);
    compare("height");
    clear_errs();

    send_frame(H, 0, 1, 1, 0, -1);
    send_frame(H, 0, 0, 1, 1, -1);
    send_frame(H, 0, 1, -1, 0, -1);
    compare("enable");

    send_frame(H, 1, 1, -1, 0, -1);
    compare("merge");

    send_frame(H, 0, 1, -1, 0, 2);
    send_frame(H, 0, 1, -1, 0, -1);
    compare("rstmid");

    for (int f = 0; f < 6; f++) begin
      nl = ($urandom_range(0, 2) == 0) ? H - 1 + int'($urandom_range(0, 2))
                                       : H;
      for (int i = 0; i < 16; i++)
        len_tab[i] = ($urandom_range(0, 4) == 0)
                   ? W - 1 + int'($urandom_range(0, 2)) : W;
      send_frame(nl, bit'($urandom_range(0, 1)), 1, -1, 0, -1);
      compare("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
